// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl
// Sequencing controller for a deterministic stochastic-computing (DSC) serial
// multiplier. A job is accepted on a ready/valid request. The controller then
// clears the datapath for one cycle and enables it for a full unary period of
// 2^(DATA_WIDTH*NUM_INPUTS) cycles. It waits one settle cycle, captures the
// datapath counter and presents it on a ready/valid response.
// An abort returns the controller to IDLE from any in-flight phase. A missing
// last-stage overflow pulse during the run is recorded in a sticky error flag.
module dsc_mul_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = DATA_WIDTH * NUM_INPUTS + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   req_data,
    input  logic                               abort,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [WXIP1-1:0]                   rsp_data,
    output logic                               mul_clr,
    output logic                               mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]   mul_opnd,
    input  logic [WXIP1-1:0]                   mul_result,
    input  logic                               mul_done,
    output logic                               busy,
    output logic                               err
);

    // Total operand bits; the run lasts 2^OPND_W cycles.
    localparam int OPND_W = DATA_WIDTH * NUM_INPUTS;
    // The run counter has one spare bit above the operand width.
    localparam int CNT_W  = OPND_W + 1;
    // Counter value on the last RUN cycle (RUN_LEN - 1).
    localparam logic [CNT_W-1:0] RUN_LAST = {1'b0, {OPND_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;
    logic                capture_s;

    logic [CNT_W-1:0]    run_cnt_r;
    logic                done_seen_r;
    logic [OPND_W-1:0]   opnd_r;
    logic [WXIP1-1:0]    rsp_data_r;
    logic                err_r;

    logic                req_ready_r;
    logic                busy_r;
    logic                mul_clr_r;
    logic                mul_en_r;
    logic                rsp_valid_r;

    // Next-state decode, plus the job-accept and result-capture strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s  = ST_CLEAR;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (run_cnt_r == RUN_LAST) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s   = ST_RESP;
                    capture_s = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                // An unreachable encoding falls back to the safe idle state.
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Control outputs registered from the next state, so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            mul_clr_r   <= 1'b0;
            mul_en_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            mul_clr_r   <= (state_s == ST_CLEAR);
            mul_en_r    <= (state_s == ST_RUN);
            rsp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Run-length counter: zeroed in CLEAR, advanced once per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_r <= CNT_ZERO;
        end else if (state_r == ST_CLEAR) begin
            run_cnt_r <= CNT_ZERO;
        end else if (state_r == ST_RUN) begin
            run_cnt_r <= run_cnt_r + CNT_ONE;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Remember whether the datapath produced its overflow pulse during this run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_seen_r <= 1'b0;
        end else if (state_r == ST_CLEAR) begin
            done_seen_r <= 1'b0;
        end else if ((state_r == ST_RUN) && mul_done) begin
            done_seen_r <= 1'b1;
        end else begin
            done_seen_r <= done_seen_r;
        end
    end

    // Operand latch: loaded only on acceptance and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opnd_r <= {OPND_W{1'b0}};
        end else if (accept_s) begin
            opnd_r <= req_data;
        end else begin
            opnd_r <= opnd_r;
        end
    end

    // Result capture at the end of SETTLE; aborted jobs leave the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_r <= {WXIP1{1'b0}};
        end else if (capture_s) begin
            rsp_data_r <= mul_result;
        end else begin
            rsp_data_r <= rsp_data_r;
        end
    end

    // Sticky error: a completed run without an overflow pulse; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (capture_s && !done_seen_r) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign mul_clr   = mul_clr_r;
    assign mul_en    = mul_en_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign mul_opnd  = opnd_r;
    assign err       = err_r;

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Self-checking bench for dsc_mul_ctrl (DATA_WIDTH=2, NUM_INPUTS=2, RUN_LEN=16).
// A behavioural DSC multiplier stands in for the datapath. A job-level
// reference model tracks each job's age since acceptance and predicts every
// output. The expected result is the plain product of the operands.
module tb_dsc_mul_ctrl;

    localparam int DW      = 2;
    localparam int NI      = 2;
    localparam int PW      = DW * NI;
    localparam int WX      = PW + 1;
    localparam int RUN_LEN = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [PW-1:0] req_data = '0;
    logic          abort = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [WX-1:0] rsp_data;
    logic          mul_clr;
    logic          mul_en;
    logic [PW-1:0] mul_opnd;
    logic [WX-1:0] mul_result;
    logic          mul_done;
    logic          busy;
    logic          err;

    logic          tie_done = 1'b0;
    logic          noise_done = 1'b0;

    int total = 0;
    int bad   = 0;

    dsc_mul_ctrl #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .abort(abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_clr(mul_clr), .mul_en(mul_en), .mul_opnd(mul_opnd),
        .mul_result(mul_result), .mul_done(mul_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural DSC multiplier datapath ----------------
    logic [PW-1:0] dsc_cnt;
    logic [WX-1:0] dsc_acc;
    logic          dsc_done;

    function automatic logic dsc_hit(input logic [PW-1:0] c, input logic [PW-1:0] op);
        logic h;
        h = 1'b1;
        for (int i = 0; i < NI; i++) begin
            if (c[i*DW +: DW] >= op[i*DW +: DW]) h = 1'b0;
        end
        return h;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dsc_cnt <= '0;
            dsc_acc <= '0;
        end else if (mul_clr) begin
            dsc_cnt <= '0;
            dsc_acc <= '0;
        end else if (mul_en) begin
            dsc_cnt <= dsc_cnt + 4'd1;
            if (dsc_hit(dsc_cnt, mul_opnd)) dsc_acc <= dsc_acc + 5'd1;
        end
    end

    assign dsc_done   = mul_en && (dsc_cnt == {PW{1'b1}});
    assign mul_result = dsc_acc;
    assign mul_done   = tie_done ? noise_done : (dsc_done | noise_done);

    // ---------------- job-level reference model ----------------
    // age 0: idle; 1: clear; 2..RUN_LEN+1: run; RUN_LEN+2: settle; RUN_LEN+3: response
    int            age;
    logic [PW-1:0] m_opnd;
    logic [WX-1:0] m_rsp_data;
    logic          m_err;
    logic          m_done;

    function automatic logic [WX-1:0] prod(input logic [PW-1:0] op);
        int p;
        p = 1;
        for (int i = 0; i < NI; i++) p = p * int'(op[i*DW +: DW]);
        return WX'(p);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            age        <= 0;
            m_opnd     <= '0;
            m_rsp_data <= '0;
            m_err      <= 1'b0;
            m_done     <= 1'b0;
        end else if (age == 0) begin
            if (req_valid) begin
                age    <= 1;
                m_opnd <= req_data;
                m_done <= 1'b0;
            end
        end else if (age <= RUN_LEN + 2) begin
            if (abort) begin
                age <= 0;
            end else begin
                if (age >= 2 && age <= RUN_LEN + 1 && mul_done) m_done <= 1'b1;
                if (age == RUN_LEN + 2) begin
                    m_rsp_data <= prod(m_opnd);
                    m_err      <= m_err | ~m_done;
                end
                age <= age + 1;
            end
        end else if (rsp_ready) begin
            age <= 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(age == 0));
        chk("busy",      32'(busy),      32'(age != 0));
        chk("mul_clr",   32'(mul_clr),   32'(age == 1));
        chk("mul_en",    32'(mul_en),    32'(age >= 2 && age <= RUN_LEN + 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(age == RUN_LEN + 3));
        chk("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
        chk("mul_opnd",  32'(mul_opnd),  32'(m_opnd));
        chk("err",       32'(err),       32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a job and return one cycle after its acceptance edge.
    task automatic send(input logic [PW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_data  = d;
        while (!req_ready && n < 60) begin
            tick;
            n++;
        end
        chk("accept_bound", 32'(n < 60), 32'd1);
        tick;
        req_valid = 1'b0;
    endtask

    // Wait for rsp_valid; k is the cycle offset from the acceptance cycle.
    task automatic wait_rsp(output int k, output int n_en, output int n_clr);
        k = 1;
        n_en = 0;
        n_clr = 0;
        while (!rsp_valid && k < 60) begin
            if (mul_en) n_en++;
            if (mul_clr) n_clr++;
            tick;
            k++;
        end
        chk("rsp_bound", 32'(rsp_valid), 32'd1);
    endtask

    int k, ne, nc;

    initial begin
        #1 rst = 1'b0;
        #20 rst = 1'b1;
        tick;
        chk("reset_ready", 32'(req_ready), 32'd1);

        // Job {2,3}, consumer always ready.
        rsp_ready = 1'b1;
        send({2'd3, 2'd2});
        wait_rsp(k, ne, nc);
        chk("lat_23", 32'(k), 32'd19);
        chk("en_cycles", 32'(ne), 32'd16);
        chk("clr_cycles", 32'(nc), 32'd1);
        chk("data_23", 32'(rsp_data), 32'd6);
        chk("model_pin_23", 32'(m_rsp_data), 32'd6);
        chk("err_23", 32'(err), 32'd0);
        tick;
        chk("idle_after_23", 32'(req_ready), 32'd1);

        // Job {3,3}, consumer stalls.
        rsp_ready = 1'b0;
        send({2'd3, 2'd3});
        wait_rsp(k, ne, nc);
        chk("lat_33", 32'(k), 32'd19);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'd9);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("ready_after_hs", 32'(req_ready), 32'd1);
        chk("valid_after_hs", 32'(rsp_valid), 32'd0);

        // Abort at RUN cycle 7, then job {1,2}.
        send({2'd3, 2'd1});
        for (int i = 0; i < 7; i++) tick;
        chk("run7_en", 32'(mul_en), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_en", 32'(mul_en), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_data", 32'(rsp_data), 32'd9);
        for (int i = 0; i < 20; i++) begin
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            tick;
        end
        send({2'd2, 2'd1});
        wait_rsp(k, ne, nc);
        chk("data_12", 32'(rsp_data), 32'd2);
        chk("model_pin_12", 32'(m_rsp_data), 32'd2);
        tick;

        // Reset mid-RUN: outputs take reset values before any clock edge.
        send({2'd3, 2'd3});
        for (int i = 0; i < 5; i++) tick;
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(mul_en), 32'd0);
        chk("rst_clr", 32'(mul_clr), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_opnd", 32'(mul_opnd), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Overflow pulse missing: job {1,1} flags err, the next job still completes.
        tie_done = 1'b1;
        send({2'd1, 2'd1});
        wait_rsp(k, ne, nc);
        chk("data_11", 32'(rsp_data), 32'd1);
        chk("err_11", 32'(err), 32'd1);
        tick;
        tie_done = 1'b0;
        send({2'd2, 2'd2});
        wait_rsp(k, ne, nc);
        chk("data_22", 32'(rsp_data), 32'd4);
        chk("err_sticky", 32'(err), 32'd1);
        tick;

        // req_valid held through RESP: second job taken only in IDLE.
        rsp_ready = 1'b0;
        send({2'd3, 2'd2});
        req_valid = 1'b1;
        req_data  = {2'd1, 2'd3};
        wait_rsp(k, ne, nc);
        for (int i = 0; i < 3; i++) begin
            chk("resp_no_ready", 32'(req_ready), 32'd0);
            chk("resp_opnd_held", 32'(mul_opnd), 32'(4'b1110));
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("hs_idle_ready", 32'(req_ready), 32'd1);
        chk("hs_idle_opnd", 32'(mul_opnd), 32'(4'b1110));
        tick;
        req_valid = 1'b0;
        chk("second_clr", 32'(mul_clr), 32'd1);
        chk("second_opnd", 32'(mul_opnd), 32'(4'b0111));
        wait_rsp(k, ne, nc);
        chk("data_second", 32'(rsp_data), 32'd3);
        tick;

        // Randomised traffic against the model, starting from a fresh reset.
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        tick;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) tie_done = ~tie_done;
            noise_done = tie_done ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 31) == 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_data   = PW'($urandom);
            abort      = ($urandom_range(0, 39) == 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
            tick;
        end
        req_valid = 1'b0;
        abort = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsc_mul_ctrl.md
DSC_MUL_CTRL -- requirements
Module: dsc_mul_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, the operand width in bits.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, the operand count per job (>=2).
REQ-003 SHALL have parameter WXIP1, default DATA_WIDTH*NUM_INPUTS+1, the result width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: the job request is valid.
REQ-007 SHALL have port req_ready, output, 1 bit: the controller can accept a job.
REQ-008 SHALL have port req_data, input, NUM_INPUTS*DATA_WIDTH bits: operands, with operand i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port abort, input, 1 bit: cancels the job in flight.
REQ-010 SHALL have port rsp_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port rsp_data, output, WXIP1 bits: the result count.
REQ-013 SHALL have port mul_clr, output, 1 bit: synchronous clear to the serial multiplier datapath.
REQ-014 SHALL have port mul_en, output, 1 bit: the datapath enable.
REQ-015 SHALL have port mul_opnd, output, NUM_INPUTS*DATA_WIDTH bits: latched operands, in the same layout as req_data.
REQ-016 SHALL have port mul_result, input, WXIP1 bits: the datapath output counter.
REQ-017 SHALL have port mul_done, input, 1 bit: the datapath last-stage overflow pulse.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 SHALL have port err, output, 1 bit: sticky done-missing error.

Function
REQ-020 SHALL implement states IDLE, CLEAR, RUN, SETTLE and RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE.
REQ-022 SHALL, on acceptance (req_valid && req_ready), latch req_data into mul_opnd and enter CLEAR.
REQ-023 SHALL hold mul_opnd stable from acceptance until the next acceptance.
REQ-024 CLEAR SHALL last 1 cycle with mul_clr=1 and mul_en=0, zeroing the run counter and the done_seen flag, then enter RUN.
REQ-025 RUN SHALL last exactly RUN_LEN = 2^(DATA_WIDTH*NUM_INPUTS) cycles with mul_en=1, counted by an internal DATA_WIDTH*NUM_INPUTS+1-bit run counter.
REQ-026 SHALL set done_seen in RUN on any cycle with mul_done=1.
REQ-027 SETTLE SHALL last 1 cycle with mul_en=0.
REQ-028 SHALL, at the end of SETTLE, register mul_result into rsp_data, set err if done_seen=0, and enter RESP.
REQ-029 SHALL drive rsp_valid=1 only in RESP, holding rsp_data stable until rsp_ready=1.
REQ-030 SHALL, on the rsp handshake, enter IDLE, with no request accepted in that same cycle.
REQ-031 SHALL give latency from acceptance at cycle T to first rsp_valid=1 at cycle T+RUN_LEN+3.
REQ-032 SHALL, on abort=1 in CLEAR, RUN or SETTLE, enter IDLE next cycle with mul_en=0, no response and rsp_data unchanged.
REQ-033 SHALL ignore abort in IDLE and RESP.
REQ-034 SHALL ignore mul_done outside RUN.
REQ-035 SHALL ignore req_valid outside IDLE, leaving req_data unsampled.
REQ-036 SHALL clear err only by reset; err SHALL NOT block further jobs.
REQ-037 SHALL drive mul_en and mul_clr directly from registered state, with no combinational path from inputs.

Reset
REQ-038 SHALL, while rst=0 at any time including mid-RUN, force state=IDLE and req_ready=1.
REQ-039 SHALL, while rst=0, force rsp_valid=0, rsp_data=0, mul_opnd=0, mul_en=0, mul_clr=0, busy=0, err=0 and the run counter to 0.
REQ-040 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification (DATA_WIDTH=2, NUM_INPUTS=2, RUN_LEN=16, behavioural DSC multiplier model attached)
REQ-041 SHALL cover: job {2,3}, rsp_ready=1 -> mul_clr 1 cycle, mul_en 16 cycles, rsp_valid at T+19, rsp_data=6, err=0.
REQ-042 SHALL cover: job {3,3}, rsp_ready low for 5 cycles -> rsp_valid and rsp_data=9 held 5 cycles, IDLE and req_ready=1 one cycle after handshake.
REQ-043 SHALL cover: abort at RUN cycle 7 -> mul_en=0 and IDLE next cycle, no rsp_valid, then a new job {1,2} -> rsp_data=2.
REQ-044 SHALL cover: rst=0 asserted mid-RUN -> all outputs at reset values immediately, before any clk edge.
REQ-045 SHALL cover: mul_done tied 0, job {1,1} -> rsp_data=1 and err=1 until reset, with a following job still completing.
REQ-046 SHALL cover: req_valid held high through RESP and the handshake -> the second job accepted in IDLE, never in RESP.
